// File: rtl/pattern_gen_pkg.sv
// Shared constants and config-word layout for the VGA test-pattern generator.
// Config word: [6:4] mode, [3:2] ramp divider, [1:0] primary select; bit 7 is reserved.
package pattern_gen_pkg;

    localparam int CFG_W       = 7;
    localparam int CFG_MODE_LSB = 4;
    localparam int CFG_MODE_W   = 3;
    localparam int CFG_DIV_LSB  = 2;
    localparam int CFG_DIV_W    = 2;
    localparam int CFG_PRI_LSB  = 0;
    localparam int CFG_PRI_W    = 2;

    localparam logic [CFG_MODE_W-1:0] MODE_PASS = 3'd0;
    localparam logic [CFG_MODE_W-1:0] MODE_RAMP = 3'd1;
    localparam logic [CFG_MODE_W-1:0] MODE_BARS = 3'd2;
    localparam logic [CFG_MODE_W-1:0] MODE_XOR  = 3'd3;

    localparam logic [CFG_PRI_W-1:0] PRI_R   = 2'd0;
    localparam logic [CFG_PRI_W-1:0] PRI_G   = 2'd1;
    localparam logic [CFG_PRI_W-1:0] PRI_B   = 2'd2;
    localparam logic [CFG_PRI_W-1:0] PRI_ALL = 2'd3;

    typedef struct packed {
        logic [CFG_MODE_W-1:0] mode;
        logic [CFG_DIV_W-1:0]  div;
        logic [CFG_PRI_W-1:0]  pri;
    } cfg_t;

    function automatic cfg_t cfg_unpack(input logic [CFG_W-1:0] w);
        cfg_t c;
        c.mode = w[CFG_MODE_LSB +: CFG_MODE_W];
        c.div  = w[CFG_DIV_LSB  +: CFG_DIV_W];
        c.pri  = w[CFG_PRI_LSB  +: CFG_PRI_W];
        return c;
    endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Beam-position, configuration and colour bundle between sync generator, pattern source and DACs.
// master drives position/config, slave (the generator) drives colour and frame count.
interface pattern_gen_if #(
    parameter int BPC = 8,
    parameter int HW  = 10
);
    logic [7:0]     cfg_in;
    logic           cfg_we;
    logic [BPC-1:0] px_in;
    logic [HW-1:0]  h;
    logic [HW-1:0]  v;
    logic           visible;
    logic           vmax;
    logic [BPC-1:0] r;
    logic [BPC-1:0] g;
    logic [BPC-1:0] b;
    logic [BPC-1:0] frame;

    modport master (
        output cfg_in, cfg_we, px_in, h, v, visible, vmax,
        input  r, g, b, frame
    );

    modport slave (
        input  cfg_in, cfg_we, px_in, h, v, visible, vmax,
        output r, g, b, frame
    );
endinterface

// File: rtl/pattern_gen_bar_counter.sv
// Colour-bar index: pixel counter 0..BAR_W-1 with saturating 3-bit bar index, zero latency on idx.
// Backpressure: none; both counters hold while not visible and restart on the h==0 pixel.
module bar_counter #(
    parameter int BAR_W = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_zero,
    input  logic       visible,
    output logic [2:0] idx
);
    localparam int CW = $clog2(BAR_W);

    logic [CW-1:0] cnt_q, cnt_d, cnt_cur;
    logic [2:0]    idx_q, idx_d;

    // The h==0 pixel already belongs to bar 0, so the clear acts on the current pixel.
    always_comb begin
        cnt_cur = h_zero ? '0 : cnt_q;
        idx     = h_zero ? 3'd0 : idx_q;
        cnt_d   = cnt_cur;
        idx_d   = idx;
        if (visible) begin
            if (cnt_cur == CW'(BAR_W - 1)) begin
                cnt_d = '0;
                if (idx != 3'd7) idx_d = idx + 3'd1;
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
        end
        if (reset) begin
            cnt_d = '0;
            idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        idx_q <= idx_d;
    end
endmodule

// File: rtl/pattern_gen.sv
// VGA test-pattern source (pass/ramp/bars/xor), 1-clock registered colour, mode switches at vmax.
// Backpressure: none, runs at pixel rate. XOR pattern compiled only with PATTERN_GEN_XOR_EN.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int BPC   = 8,
    parameter int HW    = 10,
    parameter int BAR_W = 80
) (
    input  logic           clk,
    input  logic           reset,
    pattern_gen_if.slave   bus
);
    cfg_t           pend_q, pend_d, act_q, act_d;
    logic [BPC-1:0] frame_q, frame_d;
    logic [BPC-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [BPC-1:0] ramp_a, ramp_b, ramp_c;
    logic [2:0]     idx;
    logic           unused_cfg;

    assign unused_cfg = bus.cfg_in[7];

    bar_counter #(.BAR_W(BAR_W)) u_bar (
        .clk     (clk),
        .reset   (reset),
        .h_zero  (bus.h == '0),
        .visible (bus.visible),
        .idx     (idx)
    );

    // Active config samples the pending value as it was before this cycle's write.
    always_comb begin
        pend_d  = pend_q;
        act_d   = act_q;
        frame_d = frame_q;
        if (bus.cfg_we) pend_d = cfg_unpack(bus.cfg_in[CFG_W-1:0]);
        if (bus.vmax) begin
            act_d   = pend_q;
            frame_d = frame_q + 1'b1;
        end
        if (reset) begin
            pend_d  = cfg_unpack(bus.cfg_in[CFG_W-1:0]);
            act_d   = cfg_unpack(bus.cfg_in[CFG_W-1:0]);
            frame_d = '0;
        end
    end

`ifdef PATTERN_GEN_XOR_EN
    logic [BPC-1:0] h_t;
    assign h_t = BPC'(bus.h);
`endif

    always_comb begin
        ramp_a = BPC'(bus.h >> act_q.div);
        ramp_b = BPC'(bus.v);
        ramp_c = frame_q;
        r_d = '0;
        g_d = '0;
        b_d = '0;
        case (act_q.mode)
            MODE_PASS: begin
                r_d = bus.px_in;
                g_d = bus.px_in;
                b_d = bus.px_in;
            end
            MODE_RAMP: begin
                case (act_q.pri)
                    PRI_R:   begin r_d = ramp_a; g_d = ramp_b; b_d = ramp_c; end
                    PRI_G:   begin r_d = ramp_c; g_d = ramp_a; b_d = ramp_b; end
                    PRI_B:   begin r_d = ramp_b; g_d = ramp_c; b_d = ramp_a; end
                    default: begin r_d = ramp_a; g_d = ramp_a; b_d = ramp_a; end
                endcase
            end
            MODE_BARS: begin
                r_d = {BPC{~idx[1]}};
                g_d = {BPC{~idx[2]}};
                b_d = {BPC{~idx[0]}};
            end
`ifdef PATTERN_GEN_XOR_EN
            MODE_XOR: begin
                r_d = h_t ^ ramp_b;
                g_d = h_t & ramp_b;
                b_d = h_t - ramp_b + frame_q;
            end
`endif
            default: ;
        endcase
        if (!bus.visible || reset) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        pend_q  <= pend_d;
        act_q   <= act_d;
        frame_q <= frame_d;
        r_q     <= r_d;
        g_q     <= g_d;
        b_q     <= b_d;
    end

    assign bus.r     = r_q;
    assign bus.g     = g_q;
    assign bus.b     = b_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: vector table, directed corner sequences, random run vs model.
module tb_pattern_gen;
    localparam int BPC   = 8;
    localparam int HW    = 10;
    localparam int BAR_W = 80;
    localparam int MASK  = (1 << BPC) - 1;
`ifdef PATTERN_GEN_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pattern_gen_if #(.BPC(BPC), .HW(HW)) bus ();

    pattern_gen #(.BPC(BPC), .HW(HW), .BAR_W(BAR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_pend, m_act;
    int m_frame = 0;
    int m_n = 0;          // visible pixels seen since the start of the line
    int e_r = 0, e_g = 0, e_b = 0;
    bit [2:0] bar_rgb [8];

    typedef struct {
        logic [7:0] cfg;
        int px, h, v;
        bit vis;
        int er, eg, eb;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] cfg, input bit we, input int px, input int h,
                         input int v, input bit vis, input bit vm);
        bus.cfg_in  = cfg;
        bus.cfg_we  = we;
        bus.px_in   = px[BPC-1:0];
        bus.h       = h[HW-1:0];
        bus.v       = v[HW-1:0];
        bus.visible = vis;
        bus.vmax    = vm;
    endtask

    task automatic model_step();
        int n_cur, idx, mode, dv, pri, hb, vb, a, bb, c, cr, cg, cb;
        if (reset) begin
            e_r = 0; e_g = 0; e_b = 0;
            m_frame = 0; m_n = 0;
            m_pend = bus.cfg_in; m_act = bus.cfg_in;
            return;
        end
        n_cur = (bus.h == 0) ? 0 : m_n;
        idx = n_cur / BAR_W;
        if (idx > 7) idx = 7;
        mode = int'(m_act[6:4]);
        dv   = int'(m_act[3:2]);
        pri  = int'(m_act[1:0]);
        hb = int'(bus.h) & MASK;
        vb = int'(bus.v) & MASK;
        cr = 0; cg = 0; cb = 0;
        case (mode)
            0: begin cr = int'(bus.px_in); cg = cr; cb = cr; end
            1: begin
                a = (int'(bus.h) >> dv) & MASK; bb = vb; c = m_frame;
                case (pri)
                    0: begin cr = a;  cg = bb; cb = c;  end
                    1: begin cr = c;  cg = a;  cb = bb; end
                    2: begin cr = bb; cg = c;  cb = a;  end
                    default: begin cr = a; cg = a; cb = a; end
                endcase
            end
            2: begin
                cr = bar_rgb[idx][2] ? MASK : 0;
                cg = bar_rgb[idx][1] ? MASK : 0;
                cb = bar_rgb[idx][0] ? MASK : 0;
            end
            3: if (XOR_EN) begin
                cr = hb ^ vb; cg = hb & vb; cb = (hb - vb + m_frame) & MASK;
            end
            default: ;
        endcase
        if (!bus.visible) begin cr = 0; cg = 0; cb = 0; end
        e_r = cr; e_g = cg; e_b = cb;
        m_n = n_cur + (bus.visible ? 1 : 0);
        if (m_n > 100000) m_n = 100000;
        if (bus.vmax) begin
            m_frame = (m_frame + 1) & MASK;
            m_act = m_pend;
        end
        if (bus.cfg_we) m_pend = bus.cfg_in;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_r"}, 32'(bus.r), 32'(e_r));
        chk({tag, "_g"}, 32'(bus.g), 32'(e_g));
        chk({tag, "_b"}, 32'(bus.b), 32'(e_b));
        chk({tag, "_frame"}, 32'(bus.frame), 32'(m_frame));
    endtask

    task automatic do_reset(input logic [7:0] cfg);
        reset = 1'b1;
        drive(cfg, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int xr, xg, xb, h_ctr;
        // white, yellow, cyan, green, magenta, red, blue, black as {r,g,b}
        bar_rgb = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        xr = XOR_EN ? 'h56 : 0;
        xg = XOR_EN ? 'hA1 : 0;
        xb = XOR_EN ? 'h4E : 0;
        vecs[0]  = '{8'h00, 'h5A, 5, 7, 1'b1, 'h5A, 'h5A, 'h5A};
        vecs[1]  = '{8'h00, 'h5A, 5, 7, 1'b0, 0, 0, 0};
        vecs[2]  = '{8'h10, 0, 'h123, 3, 1'b1, 'h23, 'h03, 'h00};
        vecs[3]  = '{8'h18, 0, 'h1F4, 3, 1'b1, 'h7D, 'h03, 'h00};
        vecs[4]  = '{8'h11, 0, 'h40, 'h09, 1'b1, 'h00, 'h40, 'h09};
        vecs[5]  = '{8'h12, 0, 'h40, 'h09, 1'b1, 'h09, 'h00, 'h40};
        vecs[6]  = '{8'h13, 0, 'h40, 'h09, 1'b1, 'h40, 'h40, 'h40};
        vecs[7]  = '{8'h1C, 0, 'h3FF, 'h2AB, 1'b1, 'h7F, 'hAB, 'h00};
        vecs[8]  = '{8'h20, 0, 0, 0, 1'b1, 'hFF, 'hFF, 'hFF};
        vecs[9]  = '{8'h40, 'h77, 5, 5, 1'b1, 0, 0, 0};
        vecs[10] = '{8'h30, 0, 'h1F3, 'hA5, 1'b1, xr, xg, xb};
        vecs[11] = '{8'h80, 'h33, 1, 1, 1'b1, 'h33, 'h33, 'h33};

        // Reset state
        drive(8'h00, 1'b0, 'h5A, 0, 0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk("reset_r", 32'(bus.r), 0);
        chk("reset_frame", 32'(bus.frame), 0);

        // Vector table: reset with cfg, then one pixel
        for (int i = 0; i < 12; i++) begin
            reset = 1'b1;
            drive(vecs[i].cfg, 1'b0, vecs[i].px, vecs[i].h, vecs[i].v, vecs[i].vis, 1'b0);
            tick();
            reset = 1'b0;
            tick();
            chk($sformatf("vec%0d_r", i), 32'(bus.r), 32'(vecs[i].er));
            chk($sformatf("vec%0d_g", i), 32'(bus.g), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_b", i), 32'(bus.b), 32'(vecs[i].eb));
        end

        // RAMP sweep, then divider 2 after a frame boundary
        do_reset(8'h10);
        for (int h = 0; h < 256; h++) begin
            drive(8'h10, 1'b0, 0, h, 3, 1'b1, 1'b0);
            tick();
            check_all("ramp");
            chk("ramp_r_eq_h", 32'(bus.r), 32'(h));
        end
        drive(8'h18, 1'b1, 0, 0, 3, 1'b0, 1'b0); tick();
        drive(8'h18, 1'b0, 0, 0, 3, 1'b0, 1'b1); tick();
        for (int h = 0; h < 256; h += 7) begin
            drive(8'h18, 1'b0, 0, h, 3, 1'b1, 1'b0);
            tick();
            check_all("ramp_div2");
            chk("ramp_div2_r", 32'(bus.r), 32'(h >> 2));
            chk("ramp_div2_b", 32'(bus.b), 1);
        end

        // Frame counter and wrap
        do_reset(8'h10);
        for (int k = 0; k < 4; k++) begin
            drive(8'h10, 1'b0, 0, 0, 0, 1'b0, 1'b1); tick();
        end
        chk("frame_4", 32'(bus.frame), 4);
        for (int k = 0; k < 256; k++) begin
            drive(8'h10, 1'b0, 0, 0, 0, 1'b0, 1'b1); tick();
        end
        chk("frame_wrap", 32'(bus.frame), 4);

        // BARS sweep across and past the eighth bar
        do_reset(8'h20);
        for (int h = 0; h < 700; h++) begin
            drive(8'h20, 1'b0, 0, h, 10, 1'b1, 1'b0);
            tick();
            check_all("bars");
            if (h == 40)  chk("bars_white", {8'(bus.r), 8'(bus.g), 8'(bus.b)}, 24'hFFFFFF);
            if (h == 120) chk("bars_yellow", {8'(bus.r), 8'(bus.g), 8'(bus.b)}, 24'hFFFF00);
            if (h == 600) chk("bars_black", {8'(bus.r), 8'(bus.g), 8'(bus.b)}, 0);
            if (h == 650) chk("bars_past", {8'(bus.r), 8'(bus.g), 8'(bus.b)}, 0);
        end

        // Double-buffered config
        do_reset(8'h10);
        drive(8'h10, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b0); tick();
        drive(8'h30, 1'b1, 0, 'h1F3, 'hA5, 1'b1, 1'b0); tick(); check_all("cfg_wr");
        drive(8'h00, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b0); tick();
        chk("cfg_hold", 32'(bus.r), 'hF3);
        drive(8'h00, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b1); tick();
        chk("cfg_vmax_cycle", 32'(bus.r), 'hF3);
        drive(8'h00, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b0); tick();
        chk("cfg_switched", 32'(bus.r), 32'(xr));
        check_all("cfg_switched");
        drive(8'h10, 1'b1, 0, 'h1F3, 'hA5, 1'b1, 1'b1); tick();
        drive(8'h00, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b0); tick();
        chk("cfg_coincident_delayed", 32'(bus.r), 32'(xr));
        drive(8'h00, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b1); tick();
        drive(8'h00, 1'b0, 0, 'h1F3, 'hA5, 1'b1, 1'b0); tick();
        chk("cfg_coincident_applied", 32'(bus.r), 'hF3);
        check_all("cfg_applied");

        // Reset mid-line in BARS
        do_reset(8'h20);
        drive(8'h20, 1'b0, 0, 0, 0, 1'b0, 1'b1); tick();
        drive(8'h20, 1'b0, 0, 0, 0, 1'b0, 1'b1); tick();
        for (int h = 0; h <= 200; h++) begin
            drive(8'h20, 1'b0, 0, h, 20, 1'b1, 1'b0); tick();
        end
        reset = 1'b1;
        drive(8'h20, 1'b0, 0, 201, 20, 1'b1, 1'b0); tick();
        chk("midreset_rgb", {8'(bus.r), 8'(bus.g), 8'(bus.b)}, 0);
        chk("midreset_frame", 32'(bus.frame), 0);
        reset = 1'b0;
        for (int h = 202; h < 300; h++) begin
            drive(8'h20, 1'b0, 0, h, 20, 1'b1, 1'b0); tick();
            check_all("after_reset");
            if (h == 202) chk("after_reset_idx0", {8'(bus.r), 8'(bus.g), 8'(bus.b)}, 24'hFFFFFF);
        end

        // Randomized run against the model
        do_reset(8'($urandom));
        h_ctr = 0;
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(8'($urandom), ($urandom_range(0, 19) == 0), int'($urandom_range(0, MASK)),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : h_ctr,
                  int'($urandom_range(0, 1023)),
                  (h_ctr < 640) && ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 99) == 0));
            tick();
            check_all("rand");
            h_ctr = (h_ctr == 799) ? 0 : h_ctr + 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised, fully registered VGA test-pattern generator: the next generation of the mode-selected video source that sits between the VGA sync generator and the RGB DACs. It consumes the sync generator's beam position, produces per-channel colour at configurable bit depth, and supports pass-through, ramps, colour bars and XOR patterns. Configuration is double-buffered and can be changed at runtime without tearing. The new mode takes effect only at the frame boundary.

## Interface
Parameters:
- BPC, 8, bits per colour channel (4..10)
- HW, 10, width of the h/v position inputs
- BAR_W, 80, bar width in pixels (colour-bars mode); must be ≥ 2

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- cfg_in  in  8  configuration word: [6:4] mode, [3:2] divider, [1:0] primary; [7] ignored
- cfg_we  in  1  one-cycle strobe: write cfg_in into the pending register
- px_in  in  BPC  pass-through pixel value
- h  in  HW  horizontal position from the sync generator
- v  in  HW  vertical position from the sync generator
- visible  in  1  active-video flag
- vmax  in  1  one-cycle pulse marking the last pixel of the frame
- r, g, b  out  BPC each  colour outputs, blanked
- frame  out  BPC  frame counter

## Operation
- Modes: 0 PASS, 1 RAMP, 2 BARS, 3 XOR; 4–7 output black.
- PASS: r = g = b = px_in.
- RAMP:
  - rampa = (h >> divider)[BPC-1:0]; rampb = v[BPC-1:0]; rampc = frame.
  - primary 0: {rampa, rampb, rampc}
  - primary 1: {rampc, rampa, rampb}
  - primary 2: {rampb, rampc, rampa}
  - primary 3: all channels rampa
- BARS:
  - Bar index idx (3 bits) advances every BAR_W pixels while visible. It clears when h == 0.
  - idx saturates at 7 (black) past the eighth bar.
  - Channel bits: R = ~idx[1], G = ~idx[2], B = ~idx[0]. A set bit drives all-ones, a clear bit drives 0.
  - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
- XOR: r = h^v, g = h&v, b = (h - v) + frame. All operands are truncated to BPC bits; arithmetic is mod 2^BPC.
- Frame counter: BPC bits, +1 on each vmax, wraps from all-ones to 0.
- Config double buffer:
  - During reset, pending and active both load cfg_in.
  - cfg_we loads pending.
  - On vmax, active loads pending.
  - If cfg_we and vmax coincide, active takes the old pending value, and the new value becomes active at the next vmax.
- Blanking: r, g, b are 0 whenever the pipelined visible is 0.

## Timing
- Output latency is 1 clock: values computed from h, v, visible, px_in and frame in cycle N appear on r/g/b in cycle N+1.
- The frame counter increments on the clock edge ending the vmax cycle. The first pixel of the next frame uses the new value.
- Reset values:
  - r, g, b = 0
  - frame = 0
  - idx = 0
  - bar pixel counter = 0
  - pending = active = cfg_in as sampled in the last reset cycle
- Reset asserted mid-frame takes effect on the next edge: outputs go to 0 and all counters clear.
- Bar counter:
  - Counts 0..BAR_W-1.
  - On the wrap, idx increments unless it is already 7.
  - Both hold when visible = 0.

## Configuration
- PATTERN_GEN_XOR_EN:
  - Defined: mode 3 produces the XOR pattern.
  - Undefined: the XOR datapath is not compiled, and mode 3 behaves like modes 4–7 (black).

## Structure
- Package pattern_gen_pkg holds:
  - mode constants MODE_PASS, MODE_RAMP, MODE_BARS, MODE_XOR
  - cfg field positions and widths
  - the primary-select constants
- Sub-module bar_counter (params BAR_W; ports clk, reset, h_zero, visible, idx[2:0]) encapsulates the bar pixel counter and the saturating index.

## Test plan
- Reset with cfg_in = 0x00, px_in = 0x5A, visible = 1 -> one cycle after reset release, r = g = b = 0x5A; outputs 0 while visible = 0.
- Reset with cfg_in = 0x10 (RAMP, div 0, primary R), step h = 0..255 at v = 3 -> r = h delayed by 1 clock, g = 3, b = frame; with divider = 2, r = h>>2.
- Apply 4 vmax pulses -> frame = 4; apply 2^BPC pulses -> frame wraps to the same value.
- cfg_in = 0x20 (BARS), BAR_W = 80, sweep h = 0..639:
  - h = 0..79 -> white (all 0xFF)
  - h = 80..159 -> yellow (b = 0)
  - h = 560..639 -> black
  - h ≥ 640 -> black
- Running in RAMP, strobe cfg_we with 0x30 mid-frame -> pattern unchanged until the cycle after vmax, then XOR (r = h^v) if PATTERN_GEN_XOR_EN is defined, else black; cfg_we coincident with vmax -> change delayed one frame.
- Assert reset mid-line in BARS mode -> next cycle r = g = b = 0, frame = 0, idx = 0.
